// File: rtl/tiled_matmul_engine.sv
// Tiled matrix-multiply engine: C = A x B, computed one TILE x TILE block of C
// at a time. The block is cleared, accumulated over K steps, then drained
// row-major through a valid/ready port. Operand memories persist across runs.
module tiled_matmul_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K          = 4,
  parameter int TILE       = 2,
  parameter int SIGNED     = 0,
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(K + 1),
  localparam int AW        = $clog2((M * K > K * N) ? M * K : K * N),
  localparam int RW        = $clog2(M),
  localparam int CW        = $clog2(N)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic                  load_sel,
  input  logic [AW-1:0]         load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW-1:0]         out_row,
  output logic [CW-1:0]         out_col,
  output logic [ACC_WIDTH-1:0]  out_data
);
  localparam int TM    = (M + TILE - 1) / TILE;
  localparam int TN    = (N + TILE - 1) / TILE;
  localparam int TW    = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int IW    = (TM > 1) ? $clog2(TM) : 1;
  localparam int JW    = (TN > 1) ? $clog2(TN) : 1;
  localparam int DEPTH = 2 ** AW;
  localparam int DW    = DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, FINISH} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ib_q, ib_d;
  logic [JW-1:0]       jb_q, jb_d;
  logic [KW-1:0]       kk_q, kk_d;
  logic [TW-1:0]       dr_q, dr_d;
  logic [TW-1:0]       dc_q, dc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ACC_WIDTH-1:0] acc_q [TILE][TILE];
  logic [ACC_WIDTH-1:0] acc_d [TILE][TILE];
  logic [DW-1:0]       mem_a_q [DEPTH];
  logic [DW-1:0]       mem_b_q [DEPTH];
  logic [DW-1:0]       a_op_s [TILE];
  logic [DW-1:0]       b_op_s [TILE];
  logic                load_a_s, load_b_s;
  logic                fire_s, last_col_s, last_row_s, last_tile_s;

  // Full-width product of two operands, extended to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b);
    logic [2*DW-1:0] ax, bx, p;
    if (SIGNED != 0) begin
      ax = {{DW{a[DW-1]}}, a};
      bx = {{DW{b[DW-1]}}, b};
    end else begin
      ax = {{DW{1'b0}}, a};
      bx = {{DW{1'b0}}, b};
    end
    p = ax * bx;
    if (SIGNED != 0) begin
      return {{(ACC_WIDTH-2*DW){p[2*DW-1]}}, p};
    end else begin
      return {{(ACC_WIDTH-2*DW){1'b0}}, p};
    end
  endfunction

  assign load_a_s = load_valid && !load_sel && (state_q == IDLE) && (int'(load_addr) < M * K);
  assign load_b_s = load_valid &&  load_sel && (state_q == IDLE) && (int'(load_addr) < K * N);

  // Operand write port; contents are never cleared so a rerun reuses them.
  always_ff @(posedge clock) begin
    if (load_a_s) mem_a_q[load_addr] <= load_data;
    if (load_b_s) mem_b_q[load_addr] <= load_data;
  end

  // Fetch column kk of the A tile rows and row kk of the B tile columns; padding reads zero.
  always_comb begin
    for (int r = 0; r < TILE; r++) begin
      if (int'(ib_q) * TILE + r < M) begin
        a_op_s[r] = mem_a_q[AW'((int'(ib_q) * TILE + r) * K + int'(kk_q))];
      end else begin
        a_op_s[r] = '0;
      end
    end
    for (int c = 0; c < TILE; c++) begin
      if (int'(jb_q) * TILE + c < N) begin
        b_op_s[c] = mem_b_q[AW'(int'(kk_q) * N + int'(jb_q) * TILE + c)];
      end else begin
        b_op_s[c] = '0;
      end
    end
  end

  // Out-of-range coordinates form a suffix of each row/column, so skipping is free.
  assign fire_s      = out_valid && out_ready;
  assign last_col_s  = (int'(dc_q) == TILE - 1) || (int'(jb_q) * TILE + int'(dc_q) + 1 >= N);
  assign last_row_s  = (int'(dr_q) == TILE - 1) || (int'(ib_q) * TILE + int'(dr_q) + 1 >= M);
  assign last_tile_s = (int'(ib_q) == TM - 1) && (int'(jb_q) == TN - 1);

  assign out_valid = (state_q == DRAIN);
  assign out_row   = RW'(int'(ib_q) * TILE + int'(dr_q));
  assign out_col   = CW'(int'(jb_q) * TILE + int'(dc_q));
  assign out_data  = acc_q[dr_q][dc_q];
  assign busy      = busy_q;
  assign done      = done_q;

  // Sequencer: next state, tile/step/drain counters and accumulator update.
  always_comb begin
    state_d = state_q;
    ib_d    = ib_q;
    jb_d    = jb_q;
    kk_d    = kk_q;
    dr_d    = dr_q;
    dc_d    = dc_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
        else       state_d = IDLE;
      end
      CLEAR: begin
        for (int r = 0; r < TILE; r++)
          for (int c = 0; c < TILE; c++)
            acc_d[r][c] = '0;
        kk_d    = '0;
        state_d = MAC;
      end
      MAC: begin
        for (int r = 0; r < TILE; r++)
          for (int c = 0; c < TILE; c++)
            acc_d[r][c] = acc_q[r][c] + mul_ext(a_op_s[r], b_op_s[c]);
        if (int'(kk_q) == K - 1) begin
          kk_d    = '0;
          state_d = DRAIN;
        end else begin
          kk_d = kk_q + KW'(1);
        end
      end
      DRAIN: begin
        if (!fire_s) begin
          state_d = DRAIN;
        end else if (!last_col_s) begin
          dc_d = dc_q + TW'(1);
        end else if (!last_row_s) begin
          dr_d = dr_q + TW'(1);
          dc_d = '0;
        end else begin
          dr_d = '0;
          dc_d = '0;
          if (last_tile_s) begin
            ib_d    = '0;
            jb_d    = '0;
            state_d = FINISH;
          end else if (int'(jb_q) == TN - 1) begin
            jb_d    = '0;
            ib_d    = ib_q + IW'(1);
            state_d = CLEAR;
          end else begin
            jb_d    = jb_q + JW'(1);
            state_d = CLEAR;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State, counter and accumulator registers; reset aborts any run in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ib_q    <= '0;
      jb_q    <= '0;
      kk_q    <= '0;
      dr_q    <= '0;
      dc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < TILE; r++)
        for (int c = 0; c < TILE; c++)
          acc_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      ib_q    <= ib_d;
      jb_q    <= jb_d;
      kk_q    <= kk_d;
      dr_q    <= dr_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: doc/tiled_matmul_engine.md
TILED_MATMUL_ENGINE -- requirements
Module: tiled_matmul_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width.
REQ-002 SHALL have parameter M, default 4, rows of A and C.
REQ-003 SHALL have parameter N, default 4, columns of B and C.
REQ-004 SHALL have parameter K, default 4, columns of A and rows of B.
REQ-005 SHALL have parameter TILE, default 2, side of the TILE x TILE MAC array; M, N need not be multiples of TILE.
REQ-006 SHALL have parameter SIGNED, default 0, 1 = two's-complement operands.
REQ-007 SHALL have derived ACC_WIDTH = 2*DATA_WIDTH + $clog2(K+1); AW = $clog2(max(M*K, K*N)).
REQ-008 SHALL have ports: reset reset, asynchronous, active-low; clock clock.
REQ-009 load_valid  in  1  write strobe into operand memory.
REQ-010 load_sel  in  1  0 = A, 1 = B.
REQ-011 load_addr  in  AW  row-major address: A row*K+col, B row*N+col.
REQ-012 load_data  in  DATA_WIDTH  element value.
REQ-013 start  in  1  begin multiplication.
REQ-014 busy  out  1  high from the cycle after an accepted start through the done cycle.
REQ-015 done  out  1  one-cycle pulse after the last C element is accepted.
REQ-016 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-017 out_row, out_col  out  $clog2(M), $clog2(N)  C coordinates of out_data.
REQ-018 out_data  out  ACC_WIDTH  C element, sign-extended when SIGNED=1.

Function
REQ-019 SHALL accept loads only in IDLE; loads while busy, or with load_addr >= M*K (A) / K*N (B), SHALL be ignored.
REQ-020 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, CLEAR, MAC, DRAIN, FINISH.
REQ-022 IDLE -> CLEAR on start; CLEAR zeroes all TILE*TILE accumulators in one cycle, -> MAC.
REQ-023 MAC SHALL take exactly K cycles per tile: at step kk each acc[r][c] += A[ib*TILE+r][kk] * B[kk][jb*TILE+c]; -> DRAIN after kk = K-1.
REQ-024 Operand elements with row >= M or column >= N SHALL read as zero (tile padding).
REQ-025 DRAIN SHALL present tile elements row-major (r, then c), skipping coordinates outside M x N; each element advances only on out_valid && out_ready.
REQ-026 out_valid, out_row, out_col, out_data SHALL hold stable while out_valid && !out_ready.
REQ-027 Tile order SHALL be jb fastest, then ib; after the last element of a non-final tile -> CLEAR; after the final tile -> FINISH.
REQ-028 FINISH SHALL assert done for one cycle, drop busy the following cycle, -> IDLE.
REQ-029 Products SHALL be full 2*DATA_WIDTH width; accumulation SHALL not overflow for any K within ACC_WIDTH.
REQ-030 Operand memories SHALL retain contents across runs; a second start without reloading SHALL reproduce identical C.
REQ-031 Per-run latency with out_ready held high SHALL be ceil(M/TILE)*ceil(N/TILE)*(1+K) + M*N + 1 cycles from start to done.

Reset
REQ-032 On reset low, FSM SHALL go to IDLE asynchronously; busy, done, out_valid SHALL be 0; tile counters and accumulators SHALL be 0.
REQ-033 Reset mid-run SHALL abort the run without a done pulse; operand memories need not be cleared.

Verification
REQ-034 Identity: M=N=K=4, TILE=2, A=I, B[r][c]=r*4+c, out_ready=1 -> 16 outputs row-major within tiles, C=B, done after 37 cycles.
REQ-035 Padding: M=N=K=3, TILE=2, A=B=all 2 -> 9 outputs, each 12, no coordinate >= 3, 4 tiles.
REQ-036 Backpressure: out_ready toggled 1/0 every cycle -> no element dropped or duplicated, data stable while stalled.
REQ-037 Signed: SIGNED=1, DATA_WIDTH=8, A=B=all -128, K=4 -> every C = 65536.
REQ-038 Protocol: start and loads asserted while busy -> ignored; reset low mid-MAC -> busy=0, no done, fresh start gives correct C.
